eq_coeff_loader: RTL and testbench

EQ_COEFF_LOADER -- requirements
Module: eq_coeff_loader

---
 rtl/eq_coeff_loader.sv | 130 +++++++++++++
 tb/tb_eq_coeff_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/eq_coeff_loader.sv
// eq_coeff_loader: per-channel equalizer coefficient RAM with a software write
// port and a streaming channel readout.
//
// A coefficient write is issued through a 32-bit register value that is
// already in the user_clk domain: [31] commit, [25:16] address, [15:0] coeff.
// The value is staged twice, and a write happens only on a 0->1 edge of the
// commit bit. The readout walks channels 0..2^N_CHAN_BITS-1 and restarts at 0
// whenever sync_in is high. coeff_out and sync_out trail the read address by
// two cycles.
//
// Optional feature macro: EQ_COEFF_WRCOUNT_EN (commit counter on wr_count;
// when undefined wr_count is tied to 0).
//
// Ports:
//   user_clk   in   1        clock, rising edge
//   user_rst   in   1        synchronous active-high reset
//   reg_data   in   32       software register value
//   sync_in    in   1        marks channel 0 of a spectrum
//   coeff_out  out  COEFF_W  coefficient for the delayed channel
//   sync_out   out  1        sync_in delayed by 2 cycles
//   wr_count   out  16       number of committed writes
module eq_coeff_loader #(
  parameter int unsigned        N_CHAN_BITS   = 10,
  parameter int unsigned        COEFF_W       = 16,
  parameter logic [COEFF_W-1:0] DEFAULT_COEFF = COEFF_W'(16'h0100)
) (
  input  logic               user_clk,
  input  logic               user_rst,
  input  logic [31:0]        reg_data,
  input  logic               sync_in,
  output logic [COEFF_W-1:0] coeff_out,
  output logic               sync_out,
  output logic [15:0]        wr_count
);

  localparam int unsigned DEPTH      = 1 << N_CHAN_BITS;
  localparam int unsigned ADDR_LSB   = 16;
  localparam int unsigned COMMIT_BIT = 31;

  logic [31:0]            r_s1;
  logic [31:0]            r_s2;
  logic                   r_s1_vld;
  logic                   r_s2_vld;
  logic                   r_h;
  logic                   w_commit;
  logic [N_CHAN_BITS-1:0] w_wr_addr;
  logic [COEFF_W-1:0]     w_wr_data;
  logic [N_CHAN_BITS-1:0] w_rd_addr;
  logic [N_CHAN_BITS-1:0] r_chan_cnt;
  logic [COEFF_W-1:0]     r_rd_data;
  logic                   r_sync_d1;
  logic                   w_unused;

  // Power-up content; reset never touches the array.
  logic [COEFF_W-1:0] r_mem [DEPTH] = '{default: DEFAULT_COEFF};

  // Register staging and commit history. After reset, h keeps the commit level
  // seen during reset until s2 carries real post-reset data, so a commit bit
  // held high across reset is not mistaken for a fresh 0->1 edge.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_h      <= reg_data[COMMIT_BIT];
    end else begin
      r_s1     <= reg_data;
      r_s2     <= r_s1;
      r_s1_vld <= 1'b1;
      r_s2_vld <= r_s1_vld;
      if (r_s2_vld) begin
        r_h <= r_s2[COMMIT_BIT];
      end
    end
  end

  assign w_commit  = r_s2[COMMIT_BIT] & ~r_h & ~user_rst;
  assign w_wr_addr = r_s2[ADDR_LSB +: N_CHAN_BITS];
  assign w_wr_data = r_s2[0 +: COEFF_W];

  // Fields of the staged register that carry no meaning for this RAM size.
  assign w_unused = ^r_s2;

  // Write port; the read port below samples the array in the same edge,
  // so a same-address collision returns the old word.
  always_ff @(posedge user_clk) begin
    if (w_commit) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // Channel sequencing: sync_in forces channel 0, otherwise continue counting.
  assign w_rd_addr = sync_in ? '0 : r_chan_cnt;

  // Synchronous read, output register and matching sync delay.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_chan_cnt <= '0;
      r_rd_data  <= '0;
      coeff_out  <= '0;
      r_sync_d1  <= 1'b0;
      sync_out   <= 1'b0;
    end else begin
      r_chan_cnt <= w_rd_addr + N_CHAN_BITS'(1);
      r_rd_data  <= r_mem[w_rd_addr];
      coeff_out  <= r_rd_data;
      r_sync_d1  <= sync_in;
      sync_out   <= r_sync_d1;
    end
  end

`ifdef EQ_COEFF_WRCOUNT_EN
  logic [15:0] r_wr_count;

  // Commit counter, wraps naturally at 16 bits.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign wr_count = r_wr_count;
`else
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_eq_coeff_loader.sv
// Bench for eq_coeff_loader: directed scenarios plus randomized traffic, every
// cycle compared against a transaction-level model of the coefficient table.
module tb_eq_coeff_loader;

  localparam int unsigned NB    = 10;
  localparam int unsigned DEPTH = 1 << NB;

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic [31:0] reg_data;
  logic        sync_in;
  logic [15:0] coeff_out;
  logic        sync_out;
  logic [15:0] wr_count;

  eq_coeff_loader #(
    .N_CHAN_BITS  (NB),
    .COEFF_W      (16),
    .DEFAULT_COEFF(16'h0100)
  ) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .reg_data (reg_data),
    .sync_in  (sync_in),
    .coeff_out(coeff_out),
    .sync_out (sync_out),
    .wr_count (wr_count)
  );

  always #5 user_clk = ~user_clk;

  // Reference model state: coefficient table, per-edge input history,
  // value read at each edge, channel position and commit count.
  logic [15:0] m_mem [DEPTH];
  logic [31:0] h_reg  [$];
  bit          h_rst  [$];
  bit          h_sync [$];
  logic [15:0] h_rd   [$];
  int          m_cnt;
  int          m_wr;
  bit          have_exp;
  logic [15:0] e_coeff;
  logic        e_sync;
  logic [15:0] e_wr;

  int n_pass;
  int n_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input bit rst, input logic [31:0] rd, input bit sy);
    int          e;
    int          addr;
    logic [15:0] rd_val;
    logic [31:0] v;
    h_reg.push_back(rd);
    h_rst.push_back(rst);
    h_sync.push_back(sy);
    e = h_reg.size() - 1;
    rd_val = 16'h0;
    // Read happens before any write landing on the same edge.
    if (rst) begin
      m_cnt = 0;
    end else begin
      addr   = sy ? 0 : m_cnt;
      rd_val = m_mem[addr];
      m_cnt  = (addr + 1) % DEPTH;
    end
    // A value sampled at edge e-2 that rose from 0 lands two edges later,
    // provided no reset hit any of those three edges.
    if (e >= 3 && !h_rst[e] && !h_rst[e-1] && !h_rst[e-2]) begin
      v = h_reg[e-2];
      if (v[31] && !h_reg[e-3][31]) begin
        m_mem[v[16 +: NB]] = v[15:0];
        m_wr = (m_wr + 1) & 32'hFFFF;
      end
    end
    if (rst) m_wr = 0;
    if (rst || e == 0 || h_rst[e-1]) begin
      e_coeff = 16'h0;
      e_sync  = 1'b0;
    end else begin
      e_coeff = h_rd[e-1];
      e_sync  = h_sync[e-1];
    end
    h_rd.push_back(rd_val);
`ifdef EQ_COEFF_WRCOUNT_EN
    e_wr = 16'(m_wr);
`else
    e_wr = 16'h0;
`endif
    have_exp = 1'b1;
  endtask

  // One cycle: check outputs of the previous edge, then drive the next inputs.
  task automatic step(input bit rst, input logic [31:0] rd, input bit sy);
    @(negedge user_clk);
    if (have_exp) begin
      check("coeff_out", 32'(coeff_out), 32'(e_coeff));
      check("sync_out", 32'(sync_out), 32'(e_sync));
      check("wr_count", 32'(wr_count), 32'(e_wr));
    end
    user_rst = rst;
    reg_data = rd;
    sync_in  = sy;
    model_edge(rst, rd, sy);
  endtask

  task automatic idle(input int n, input logic [31:0] rd);
    for (int i = 0; i < n; i++) step(1'b0, rd, 1'b0);
  endtask

  // Software protocol: {0,a,c}, {1,a,c}, {0,a,c}, two cycles each.
  task automatic sw_write(input logic [9:0] a, input logic [15:0] c);
    logic [31:0] v;
    v = {1'b0, 5'd0, a, c};
    idle(2, v);
    v[31] = 1'b1;
    idle(2, v);
    v[31] = 1'b0;
    idle(2, v);
  endtask

  logic [31:0] cur;
  logic [31:0] nv;
  int          rst_left;

  initial begin
    n_pass   = 0;
    n_total  = 0;
    have_exp = 1'b0;
    m_cnt    = 0;
    m_wr     = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0100;
    user_rst = 1'b1;
    reg_data = 32'h0;
    sync_in  = 1'b0;

    // Reset, then post-reset readout of a full spectrum.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    idle(DEPTH + 4, 32'h0);
    check("reset_wr_count", 32'(wr_count), 32'h0);

    // Single write to channel 5 and readback.
    step(1'b0, 32'h0005_ABCD, 1'b0);
    step(1'b0, 32'h8005_ABCD, 1'b0);
    step(1'b0, 32'h0005_ABCD, 1'b0);
    idle(3, 32'h0005_ABCD);
    step(1'b0, 32'h0005_ABCD, 1'b1);
    idle(DEPTH + 4, 32'h0005_ABCD);
    check("ch5_table", 32'(m_mem[5]), 32'h0000_ABCD);

    // Commit bit held high, then reset while still held.
    idle(50, 32'h8003_1111);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h8003_1111, 1'b0);
    idle(20, 32'h8003_1111);
    idle(4, 32'h0003_1111);

    // Address truncation and counter wrap with no sync.
    sw_write(10'h3FF, 16'h2222);
    idle(2, 32'h83FF_2222 & 32'h7FFF_FFFF);
    step(1'b0, 32'h0400_3333, 1'b0);
    step(1'b0, 32'h8400_3333, 1'b0);
    step(1'b0, 32'h0400_3333, 1'b0);
    idle(2 * DEPTH + 8, 32'h0400_3333);

    // Write to address 7 landing on the edge that reads address 7.
    idle(3, 32'h0007_BEEF);
    step(1'b0, 32'h0007_BEEF, 1'b1);
    idle(4, 32'h0007_BEEF);
    idle(3, 32'h8007_BEEF);
    idle(DEPTH, 32'h0007_BEEF);
    step(1'b0, 32'h0007_BEEF, 1'b1);
    idle(20, 32'h0007_BEEF);

    // Early sync at channel ~300.
    idle(300, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    idle(20, 32'h0);

    // Ten commits to distinct channels.
    for (int i = 0; i < 10; i++) sw_write(10'(100 + i), 16'(16'h5000 + i));
    step(1'b0, 32'h0, 1'b1);
    idle(140, 32'h0);

    // Randomized traffic: register toggles, sync pulses, short resets.
    cur      = 32'h0;
    rst_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0) begin
        nv     = $urandom();
        nv[31] = ~cur[31];
        cur    = nv;
      end
      if (rst_left == 0 && $urandom_range(700) == 0) rst_left = $urandom_range(3, 1);
      if (rst_left > 0) begin
        step(1'b1, cur, 1'($urandom_range(1)));
        rst_left--;
      end else begin
        step(1'b0, cur, ($urandom_range(300) == 0));
      end
    end
    idle(4, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    idle(DEPTH + 4, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
